// File: rtl/axis_burst_packer_if.sv
// AXI-Stream style link used on both sides of the burst packer.
// Width is set per instance: wide beats upstream, one channel word downstream.
interface axis_burst_packer_if #(
  parameter int DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  // A word moves on a rising clk edge where tvalid and tready are both high;
  // the master keeps tdata/tlast stable while tvalid is high and tready is low.
  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_burst_packer.sv
// Packs one peak burst of wide multi-channel beats into a framed word stream:
// sync, sequence/length, timestamp, serialized channel words, then a trailer.
module axis_burst_packer #(
  parameter int          NUM_CHANNELS  = 4,
  parameter int          CHANNEL_WIDTH = 32,
  parameter int          BURST_LENGTH  = 32,
  parameter logic [31:0] SYNC_WORD     = 32'hA55A0F0F
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axis_burst_packer_if.slave    s_axis,
  axis_burst_packer_if.master   m_axis,
  output logic [2:0]            dbg_state
);

  localparam int                BEAT_W     = NUM_CHANNELS * CHANNEL_WIDTH;
  localparam int                IDX_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [15:0]       BURST_LEN  = 16'(BURST_LENGTH);
  localparam logic [15:0]       BURST_LAST = 16'(BURST_LENGTH - 1);
  localparam logic [IDX_W-1:0]  CHAN_LAST  = IDX_W'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_SYNC = 3'd1,
    HDR_SEQ  = 3'd2,
    HDR_TS   = 3'd3,
    PAYLOAD  = 3'd4,
    TRAILER  = 3'd5
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [31:0]              ts;
  logic [31:0]              ts_lat;
  logic [15:0]              seq;
  logic [15:0]              beat_cnt;
  logic [IDX_W-1:0]         chan_idx;
  logic [BEAT_W-1:0]        hold_reg;
  logic                     hold_valid;
  logic                     hold_last;
  logic                     flag_early;
  logic                     flag_forced;
  logic                     s_frame;
  logic                     m_frame;
  logic [CHANNEL_WIDTH-1:0] chan_word [NUM_CHANNELS];

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign chan_word[c] = hold_reg[c*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  end

  assign s_frame   = s_axis.tvalid & s_axis.tready;
  assign m_frame   = m_axis.tvalid & m_axis.tready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    s_axis.tready = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = '0;
    m_axis.tlast  = 1'b0;
    case (state)
      // The beat that wakes us stays pending until PAYLOAD accepts it.
      IDLE: begin
        if (s_axis.tvalid) state_next = HDR_SYNC;
      end
      HDR_SYNC: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = CHANNEL_WIDTH'(SYNC_WORD);
        if (m_axis.tready) state_next = HDR_SEQ;
      end
      HDR_SEQ: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = CHANNEL_WIDTH'({seq, BURST_LEN});
        if (m_axis.tready) state_next = HDR_TS;
      end
      HDR_TS: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = CHANNEL_WIDTH'(ts_lat);
        if (m_axis.tready) state_next = PAYLOAD;
      end
      // Single holding register: accept only when empty, which costs one
      // bubble per beat but keeps the output word trivially stable.
      PAYLOAD: begin
        s_axis.tready = ~hold_valid;
        m_axis.tvalid = hold_valid;
        m_axis.tdata  = hold_valid ? chan_word[chan_idx] : '0;
        if (hold_valid && m_axis.tready && (chan_idx == CHAN_LAST) && hold_last) begin
          state_next = TRAILER;
        end
      end
      TRAILER: begin
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = 1'b1;
        m_axis.tdata  = CHANNEL_WIDTH'({flag_early, flag_forced, 14'b0, beat_cnt});
        if (m_axis.tready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts          <= '0;
      ts_lat      <= '0;
      seq         <= '0;
      beat_cnt    <= '0;
      chan_idx    <= '0;
      hold_reg    <= '0;
      hold_valid  <= 1'b0;
      hold_last   <= 1'b0;
      flag_early  <= 1'b0;
      flag_forced <= 1'b0;
    end else begin
      ts <= ts + 32'd1;

      if (state == IDLE && s_axis.tvalid) ts_lat <= ts;

      if (state == PAYLOAD) begin
        if (s_frame) begin
          hold_reg   <= BEAT_W'(s_axis.tdata);
          hold_last  <= s_axis.tlast | (beat_cnt == BURST_LAST);
          hold_valid <= 1'b1;
          beat_cnt   <= beat_cnt + 16'd1;
          if (s_axis.tlast && (beat_cnt < BURST_LAST)) flag_early <= 1'b1;
          // Burst cut at the maximum length; the rest of it becomes a new packet.
          if (!s_axis.tlast && (beat_cnt == BURST_LAST)) flag_forced <= 1'b1;
        end
        if (m_frame) begin
          if (chan_idx == CHAN_LAST) begin
            chan_idx   <= '0;
            hold_valid <= 1'b0;
          end else begin
            chan_idx <= chan_idx + 1'b1;
          end
        end
      end

      if (state == TRAILER && m_frame) begin
        seq         <= seq + 16'd1;
        beat_cnt    <= '0;
        flag_early  <= 1'b0;
        flag_forced <= 1'b0;
      end
    end
  end

  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_axis.tvalid && !m_axis.tready) |=> (m_axis.tvalid && $stable(m_axis.tdata)));

  a_last_valid: assert property (@(posedge clk) disable iff (!rst_n)
    m_axis.tlast |-> m_axis.tvalid);

endmodule

// File: tb/tb_axis_burst_packer.sv
// Scoreboard bench for axis_burst_packer: drives bursts, predicts every output
// word (timestamp via a cycle-accurate idle model) and compares in order.
module tb_axis_burst_packer;

  localparam int          NC   = 4;
  localparam int          CW   = 32;
  localparam int          BL   = 32;
  localparam logic [31:0] SYNC = 32'hA55A0F0F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  axis_burst_packer_if #(.DATA_W(NC*CW)) s_if ();
  axis_burst_packer_if #(.DATA_W(CW))    m_if ();

  axis_burst_packer #(
    .NUM_CHANNELS (NC),
    .CHANNEL_WIDTH(CW),
    .BURST_LENGTH (BL),
    .SYNC_WORD    (SYNC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_axis   (s_if),
    .m_axis   (m_if),
    .dbg_state(dbg_state)
  );

  // exp_q entry: [33] timestamp word (value from ts_q), [32] tlast, [31:0] data
  logic [33:0] exp_q[$];
  logic [31:0] ts_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mts = '0;
  bit          midle = 1'b1;
  int          cyc = 0;
  int          idle_cyc = 0;
  int          w0_cyc = 0;
  int          w3_cyc = 0;
  int          pkt_words = 0;
  logic [31:0] last_ts = '0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  bit          bp_mode = 1'b0;
  bit          abort = 1'b0;
  logic [15:0] mseq = '0;
  int          pkt_beats = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_if.tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor, stall-stability checker and idle/timestamp predictor.
  always @(negedge clk) begin
    logic [33:0] e;
    logic [31:0] exp_d;
    cyc++;
    if (!rst_n) begin
      mts        = '0;
      midle      = 1'b1;
      pkt_words  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(m_if.tvalid), 64'(1));
        check("stall_data", 64'(m_if.tdata), 64'(prev_data));
      end
      if (midle && s_if.tvalid) begin
        ts_q.push_back(mts);
        idle_cyc = cyc;
        midle    = 1'b0;
      end
      if (m_if.tvalid && m_if.tready) begin
        if (pkt_words == 0) w0_cyc = cyc;
        if (pkt_words == 3) w3_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("spurious_word", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          exp_d = e[31:0];
          if (e[33]) begin
            if (ts_q.size() == 0) check("ts_predicted", 64'(ts_q.size()), 64'(1));
            else exp_d = ts_q.pop_front();
            last_ts = m_if.tdata;
          end
          check("word", 64'(m_if.tdata), 64'(exp_d));
          check("tlast", 64'(m_if.tlast), 64'(e[32]));
        end
        pkt_words = m_if.tlast ? 0 : pkt_words + 1;
        if (m_if.tlast) midle = 1'b1;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      mts++;
    end
  end

  // Called at posedge+1; returns at posedge+1.
  task automatic send_burst(input int nbeats, input int last_at);
    for (int b = 0; b < nbeats && !abort; b++) begin
      logic             tl;
      logic [NC*CW-1:0] d;
      int               waited;
      tl = (b + 1 == last_at);
      for (int c = 0; c < NC; c++) d[c*CW +: CW] = {16'(b), 16'(c)};
      if (pkt_beats == 0) begin
        exp_q.push_back({2'b00, SYNC});
        exp_q.push_back({2'b00, mseq, 16'(BL)});
        exp_q.push_back({2'b10, 32'h0});
      end
      for (int c = 0; c < NC; c++) exp_q.push_back({2'b00, d[c*CW +: CW]});
      pkt_beats++;
      if (tl || pkt_beats == BL) begin
        exp_q.push_back({2'b01, (tl && pkt_beats < BL), (!tl && pkt_beats == BL),
                         14'b0, 16'(pkt_beats)});
        mseq++;
        pkt_beats = 0;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tlast  = tl;
      waited = 0;
      forever begin
        @(negedge clk);
        if (abort || s_if.tready || waited >= 2000) break;
        waited++;
      end
      if (waited >= 2000) check("beat_timeout", 64'(waited), 64'(0));
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_exp_q", 64'(exp_q.size()), 64'(0));
    check("drain_ts_q", 64'(ts_q.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    ts_q.delete();
    mseq      = '0;
    pkt_beats = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_m_tvalid"}, 64'(m_if.tvalid), 64'(0));
    check({tag, "_m_tlast"}, 64'(m_if.tlast), 64'(0));
    check({tag, "_m_tdata"}, 64'(m_if.tdata), 64'(0));
    check({tag, "_s_tready"}, 64'(s_if.tready), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(0));
  endtask

  initial begin
    int n;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    do_reset();
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;

    send_burst(32, 32);
    drain();
    check("lat_first_hdr", 64'(w0_cyc - idle_cyc), 64'(1));
    check("lat_first_payload", 64'(w3_cyc - idle_cyc), 64'(5));

    send_burst(32, 32);
    drain();

    send_burst(5, 5);
    drain();

    send_burst(40, 40);
    drain();

    bp_mode = 1'b1;
    send_burst(32, 32);
    drain();
    bp_mode = 1'b0;

    abort = 1'b0;
    fork
      send_burst(32, 32);
      begin
        n = 0;
        while (pkt_words < 50 && n < 3000) begin
          @(negedge clk);
          n++;
        end
        check("reach_word50", 64'(pkt_words >= 50), 64'(1));
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        abort       = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("midrst");
      end
    join
    exp_q.delete();
    ts_q.delete();
    mseq      = '0;
    pkt_beats = 0;
    abort     = 1'b0;
    @(posedge clk);
    #1;

    send_burst(8, 8);
    drain();
    check("ts_near_zero", 64'(last_ts < 32'd32), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
